output_port_arbiter: RTL and testbench
======================================

Name: output_port_arbiter

Overview:
- Round-robin scheduler that shares one network egress link between the NUM_OUT_PORTS output-port FIFOs of a leaf interface.
- Sits between the output-port cluster and the leaf's upstream switch port.
- Watches per-port empty flags, issues one-hot read enables, muxes the selected packet into a registered output stage with a valid/ready handshake.

Parameters:
- PACKET_BITS, 97, width of one network packet
- NUM_OUT_PORTS, 7, number of output-port FIFOs arbitrated
- SEL_BITS, 3, width of grant index; must equal clog2(NUM_OUT_PORTS), minimum 1

Ports:
- clk  input  1  clock
- reset  input  1  reset; asynchronous, active-low
- arb_en  input  1  1 = new grants allowed; 0 = freeze grants, in-flight packet still drains
- empty  input  NUM_OUT_PORTS  per-port FIFO empty flags
- internal_out  input  PACKET_BITS*NUM_OUT_PORTS  per-port FIFO head data (first-word-fall-through; valid when !empty)
- rd_en_sel  output  NUM_OUT_PORTS  one-hot pop strobe to selected FIFO
- dout  output  PACKET_BITS  registered packet to network
- vld_out  output  1  dout valid
- rdy_in  input  1  network accepts dout this cycle
- grant_idx  output  SEL_BITS  index of port that sourced current dout

Behaviour:
- Reset (reset=0, async): vld_out=0, dout=0, grant_idx=0, rd_en_sel=0, rr pointer last=NUM_OUT_PORTS-1, so port 0 has first priority.
- Output register "free" = !vld_out | rdy_in.
- Grant condition, combinational: arb_en & free & (|~empty).
- When granted, winner = first non-empty port scanning last+1, last+2, … wrapping modulo NUM_OUT_PORTS.
- rd_en_sel = onehot(winner) in the grant cycle, else all zero.
- rd_en_sel is never asserted for an empty port and never more than one bit.
- At the next edge after a grant: dout <= internal_out[winner], vld_out <= 1, grant_idx <= winner, last <= winner.
- Latency: non-empty flag to vld_out is 1 cycle.
- Throughput: 1 packet/cycle while rdy_in=1 and packets remain.
- Free but no grant (all empty or arb_en=0): if rdy_in consumed the packet, vld_out <= 0 at the edge; dout and grant_idx hold their values.
- Back-pressure: while vld_out=1 and rdy_in=0, dout, vld_out and grant_idx are held stable and rd_en_sel=0. No packet is dropped or duplicated.
- Simultaneous rdy_in=1 and new grant: old packet is accepted and new packet loaded in the same edge, with no bubble.
- Single requester: the same port may win every cycle; the pointer lets it re-win only when no other port is non-empty.
- arb_en falling while vld_out=1: current packet still completes on rdy_in; no further grants.
- Reset asserted mid-transfer: the packet is lost, outputs return to reset values immediately, pointer returns to its reset value.
- Indexing: NUM_OUT_PORTS need not be a power of two; wrap uses compare-and-subtract, not bit truncation.

Optional Feature:
- Macro OUT_ARB_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0], which counts cycles with vld_out=1 & rdy_in=0. It saturates at 16'hFFFF and clears on reset.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package out_arb_pkg: default PACKET_BITS and NUM_OUT_PORTS constants, clog2 function, grant-index typedef.
- Sub-module rr_pick: purely combinational rotate-priority picker (inputs req, last; outputs onehot, idx, any). Instantiated once.

Test Plan:
- Reset, all empty=1, rdy_in=1, arb_en=1 -> rd_en_sel=0, vld_out stays 0 for 20 cycles.
- empty=7'b1111010 (ports 0,2 non-empty, both FIFOs held non-empty), rdy_in=1 -> grant sequence 0,2,0,2…; vld_out continuous; dout matches source packet each cycle.
- All 7 ports non-empty, rdy_in toggling 1,0,1,0 -> grants 0..6 in order; dout/grant_idx stable during rdy_in=0 cycles; zero rd_en_sel during stalls.
- Only port 5 with 3 packets, rdy_in=1 -> three consecutive grants of 5; vld_out drops 1 cycle after the last pop.
- arb_en=0 while a packet is pending with rdy_in=0, then rdy_in=1 -> pending packet accepted, no new rd_en_sel, vld_out -> 0.
- Assert reset while vld_out=1 -> vld_out=0 without waiting for a clock; after release, first grant goes to lowest non-empty port. With OUT_ARB_STALL_CNT_EN defined, 70000 stall cycles -> stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/out_arb_pkg.sv
// ============================================================================
// Module  : out_arb_pkg
// Purpose : Shared constants, helper function and types for the output-port
//           arbiter (output_port_arbiter and its rr_pick picker).
// Contents: DEF_PACKET_BITS, DEF_NUM_OUT_PORTS, clog2(), grant_idx_t
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package out_arb_pkg;

  localparam int DEF_PACKET_BITS   = 97;
  localparam int DEF_NUM_OUT_PORTS = 7;

  // Ceiling log2, floored at 1 so that a single-port build still has a
  // one-bit grant index.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

  typedef logic [clog2(DEF_NUM_OUT_PORTS)-1:0] grant_idx_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Purpose : Combinational rotate-priority picker. Scans last+1, last+2, ...
//           modulo NUM, returns the first requesting position.
// Ports   : req_i     [NUM]      request vector
//           last_i    [SEL_BITS] previous winner (scan starts after it)
//           onehot_o  [NUM]      one-hot winner (zero when no request)
//           idx_o     [SEL_BITS] binary winner index (zero when no request)
//           any_o                at least one request present
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NUM      = 7,
  parameter int SEL_BITS = 3
) (
  input  logic [NUM-1:0]      req_i,
  input  logic [SEL_BITS-1:0] last_i,
  output logic [NUM-1:0]      onehot_o,
  output logic [SEL_BITS-1:0] idx_o,
  output logic                any_o
);

  // One extra bit so last+k (at most 2*NUM-1) never overflows before the
  // wrap; NUM need not be a power of two, so the wrap is compare-and-subtract.
  logic [SEL_BITS:0] cand;

  always_comb begin
    cand     = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    onehot_o = '0;
    // Walk farthest-first so the nearest requester after last_i is the
    // final assignment and therefore the winner.
    for (int k = NUM; k >= 1; k--) begin
      cand = {1'b0, last_i} + (SEL_BITS+1)'(k);
      if (cand >= (SEL_BITS+1)'(NUM)) begin
        cand = cand - (SEL_BITS+1)'(NUM);
      end
      if (req_i[cand[SEL_BITS-1:0]]) begin
        idx_o = cand[SEL_BITS-1:0];
        any_o = 1'b1;
      end
    end
    if (any_o) begin
      onehot_o[idx_o] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/output_port_arbiter.sv
// ============================================================================
// Module  : output_port_arbiter
// Purpose : Round-robin scheduler sharing one egress link between the
//           output-port FIFOs of a leaf interface. Pops the winning FIFO and
//           loads its head packet into a registered valid/ready output stage.
// Ports   : clk           clock
//           reset         asynchronous active-low reset
//           arb_en        1 = new grants allowed, 0 = freeze (drain only)
//           empty         per-port FIFO empty flags
//           internal_out  per-port FIFO head data (FWFT), port p at slice p
//           rd_en_sel     one-hot pop strobe to the granted FIFO
//           dout          registered packet to network
//           vld_out       dout valid
//           rdy_in        network accepts dout this cycle
//           grant_idx     port that sourced the current dout
//           stall_cnt     saturating count of vld_out & !rdy_in cycles
//                         (present only when OUT_ARB_STALL_CNT_EN is defined)
// Config  : OUT_ARB_STALL_CNT_EN - adds the stall_cnt output and counter
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module output_port_arbiter
  import out_arb_pkg::*;
#(
  parameter int PACKET_BITS   = DEF_PACKET_BITS,
  parameter int NUM_OUT_PORTS = DEF_NUM_OUT_PORTS,
  parameter int SEL_BITS      = clog2(NUM_OUT_PORTS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               arb_en,
  input  logic [NUM_OUT_PORTS-1:0]           empty,
  input  logic [PACKET_BITS*NUM_OUT_PORTS-1:0] internal_out,
  output logic [NUM_OUT_PORTS-1:0]           rd_en_sel,
  output logic [PACKET_BITS-1:0]             dout,
  output logic                               vld_out,
  input  logic                               rdy_in,
  output logic [SEL_BITS-1:0]                grant_idx
`ifdef OUT_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                        stall_cnt
`endif
);

  localparam logic [SEL_BITS-1:0] LAST_RST = SEL_BITS'(NUM_OUT_PORTS - 1);

  logic [PACKET_BITS-1:0]   dout_q, dout_d;
  logic                     vld_q, vld_d;
  logic [SEL_BITS-1:0]      gidx_q, gidx_d;
  logic [SEL_BITS-1:0]      last_q, last_d;

  logic [NUM_OUT_PORTS-1:0] pick_onehot;
  logic [SEL_BITS-1:0]      pick_idx;
  logic                     pick_any;
  logic [PACKET_BITS-1:0]   pick_data;
  logic                     free;
  logic                     grant;

  rr_pick #(
    .NUM      (NUM_OUT_PORTS),
    .SEL_BITS (SEL_BITS)
  ) u_rr_pick (
    .req_i    (~empty),
    .last_i   (last_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // Output stage can take a new packet when empty or being drained now.
  assign free = !vld_q || rdy_in;

  // Reset is folded in so no FIFO is popped while the block is held in
  // reset (the pop would otherwise lose a packet the stage cannot capture).
  assign grant = reset && arb_en && free && pick_any;

  assign rd_en_sel = grant ? pick_onehot : '0;

  always_comb begin
    pick_data = '0;
    for (int p = 0; p < NUM_OUT_PORTS; p++) begin
      if (pick_idx == SEL_BITS'(p)) begin
        pick_data = internal_out[p*PACKET_BITS +: PACKET_BITS];
      end
    end
  end

  always_comb begin
    dout_d = dout_q;
    vld_d  = vld_q;
    gidx_d = gidx_q;
    last_d = last_q;
    if (grant) begin
      dout_d = pick_data;
      vld_d  = 1'b1;
      gidx_d = pick_idx;
      last_d = pick_idx;
    end else if (free) begin
      // Nothing new to load: the old packet (if any) was accepted.
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
      gidx_q <= '0;
      last_q <= LAST_RST;
    end else begin
      dout_q <= dout_d;
      vld_q  <= vld_d;
      gidx_q <= gidx_d;
      last_q <= last_d;
    end
  end

  assign dout      = dout_q;
  assign vld_out   = vld_q;
  assign grant_idx = gidx_q;

`ifdef OUT_ARB_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (vld_q && !rdy_in && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_output_port_arbiter.sv
// ============================================================================
// Module  : tb_output_port_arbiter
// Purpose : Directed self-checking bench for output_port_arbiter (7 ports,
//           97-bit packets). Stall counter section active when
//           OUT_ARB_STALL_CNT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_output_port_arbiter;

  localparam int PB = 97;
  localparam int N  = 7;
  localparam int SB = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              arb_en;
  logic [N-1:0]      empty;
  logic [PB*N-1:0]   internal_out;
  logic [N-1:0]      rd_en_sel;
  logic [PB-1:0]     dout;
  logic              vld_out;
  logic              rdy_in;
  logic [SB-1:0]     grant_idx;
`ifdef OUT_ARB_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  output_port_arbiter #(
    .PACKET_BITS   (PB),
    .NUM_OUT_PORTS (N),
    .SEL_BITS      (SB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .arb_en       (arb_en),
    .empty        (empty),
    .internal_out (internal_out),
    .rd_en_sel    (rd_en_sel),
    .dout         (dout),
    .vld_out      (vld_out),
    .rdy_in       (rdy_in),
    .grant_idx    (grant_idx)
`ifdef OUT_ARB_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [PB-1:0] pkt(input int p, input int n);
    return {8'(p), 8'(n), 81'h1_2345_6789_ABCD_EF01_2345};
  endfunction

  task automatic load_all();
    for (int p = 0; p < N; p++) begin
      internal_out[p*PB +: PB] = pkt(p, 0);
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs already driven: checks the pop strobe
  // mid-cycle, then the registered outputs just after the next edge.
  task automatic cyc(input string tag, input logic [N-1:0] exp_rd,
                     input logic exp_vld, input logic [SB-1:0] exp_g,
                     input logic [PB-1:0] exp_dout);
    #3;
    chk({tag, "/rd_en_sel"}, 128'(rd_en_sel), 128'(exp_rd));
    @(posedge clk);
    #1;
    chk({tag, "/vld_out"}, 128'(vld_out), 128'(exp_vld));
    chk({tag, "/grant_idx"}, 128'(grant_idx), 128'(exp_g));
    chk({tag, "/dout"}, 128'(dout), 128'(exp_dout));
  endtask

  task automatic rst_pulse();
    reset = 1'b0;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset        = 1'b1;
    arb_en       = 1'b1;
    rdy_in       = 1'b1;
    empty        = '1;
    internal_out = '0;
    load_all();
    #2 reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst/vld_out", 128'(vld_out), 128'(0));
    chk("rst/dout", 128'(dout), 128'(0));
    chk("rst/grant_idx", 128'(grant_idx), 128'(0));
    chk("rst/rd_en_sel", 128'(rd_en_sel), 128'(0));
    reset = 1'b1;

    // 1: all empty -> nothing happens for 20 cycles
    for (int i = 0; i < 20; i++) begin
      cyc("idle", 7'b0000000, 1'b0, 3'd0, '0);
    end

    // 2: ports 0 and 2 permanently non-empty -> 0,2,0,2,...
    empty = 7'b1111010;
    for (int i = 0; i < 3; i++) begin
      cyc("alt0", 7'b0000001, 1'b1, 3'd0, pkt(0, 0));
      cyc("alt2", 7'b0000100, 1'b1, 3'd2, pkt(2, 0));
    end
    empty = '1;
    cyc("alt_end", 7'b0000000, 1'b0, 3'd2, pkt(2, 0));

    // 3: all ports non-empty, rdy_in toggling -> grants 0..6, held on stalls
    rst_pulse();
    empty = '0;
    for (int i = 0; i < N; i++) begin
      rdy_in = 1'b1;
      cyc("rr_grant", 7'(1 << i), 1'b1, 3'(i), pkt(i, 0));
      rdy_in = 1'b0;
      cyc("rr_stall", 7'b0000000, 1'b1, 3'(i), pkt(i, 0));
    end
    rdy_in = 1'b1;
    empty  = '1;
    cyc("rr_end", 7'b0000000, 1'b0, 3'd6, pkt(6, 0));

    // 4: only port 5, three packets, back-to-back
    empty = 7'b1011111;
    for (int n = 0; n < 3; n++) begin
      internal_out[5*PB +: PB] = pkt(5, n);
      cyc("p5", 7'b0100000, 1'b1, 3'd5, pkt(5, n));
    end
    empty = '1;
    cyc("p5_end", 7'b0000000, 1'b0, 3'd5, pkt(5, 2));
    load_all();

    // 5: arb_en dropped while a packet is pending
    empty  = 7'b1111101;
    rdy_in = 1'b0;
    cyc("en_load", 7'b0000010, 1'b1, 3'd1, pkt(1, 0));
    arb_en = 1'b0;
    empty  = 7'b1110101;
    cyc("en_hold", 7'b0000000, 1'b1, 3'd1, pkt(1, 0));
    rdy_in = 1'b1;
    cyc("en_drain", 7'b0000000, 1'b0, 3'd1, pkt(1, 0));
    cyc("en_idle", 7'b0000000, 1'b0, 3'd1, pkt(1, 0));

    // 6: async reset mid-transfer, pointer returns to reset value
    arb_en = 1'b1;
    empty  = 7'b1111110;
    cyc("ar_load", 7'b0000001, 1'b1, 3'd0, pkt(0, 0));
    rdy_in = 1'b0;
    empty  = '1;
    #2;
    chk("ar_pre/vld_out", 128'(vld_out), 128'(1));
    reset = 1'b0;
    #1;
    chk("ar_async/vld_out", 128'(vld_out), 128'(0));
    chk("ar_async/dout", 128'(dout), 128'(0));
    chk("ar_async/grant_idx", 128'(grant_idx), 128'(0));
    empty  = 7'b1110110;
    rdy_in = 1'b1;
    #1;
    chk("ar_async/rd_en_sel", 128'(rd_en_sel), 128'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc("ar_first", 7'b0000001, 1'b1, 3'd0, pkt(0, 0));
    cyc("ar_second", 7'b0001000, 1'b1, 3'd3, pkt(3, 0));

`ifdef OUT_ARB_STALL_CNT_EN
    rst_pulse();
    empty = '1;
    #1;
    chk("sc/reset", 128'(stall_cnt), 128'(0));
    @(posedge clk);
    #1;
    empty = 7'b1111110;
    cyc("sc_load", 7'b0000001, 1'b1, 3'd0, pkt(0, 0));
    empty  = '1;
    rdy_in = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("sc/five", 128'(stall_cnt), 128'(5));
    repeat (70000) @(posedge clk);
    #1;
    chk("sc/saturate", 128'(stall_cnt), 128'(16'hFFFF));
    chk("sc/vld_held", 128'(vld_out), 128'(1));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
